// File: rtl/vga_frame_reader_pkg.sv
// Helpers shared by the frame reader files.
// Pure elaboration-time functions; no logic, no latency.
// No flow control of its own.
package vga_frame_reader_pkg;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga.svh
// Shared VGA timing defaults used by display-path blocks.
// Visible area only; blanking intervals live with the timing generator.
`ifndef VGA_SVH
`define VGA_SVH
`define H_DISPLAY 640
`define V_DISPLAY 480
`endif

// File: rtl/vga_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata is the head entry (zero when empty).
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: full/count tell the producer; pushing while full is only legal with a pop.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module vga_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    // Storage is not reset, so mask the head to keep the output clean when empty.
    assign rdata = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
            // When full with push and pop together, wr_q == rd_q: the head is
            // overwritten at the same edge it leaves, which is what we want.
            if (push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Streams whole frames from a word-addressed frame buffer into a small pixel FIFO.
// Latency: first request one cycle after start; one pixel/cycle sustained at memory latency 1.
// Backpressure: requests are credit-limited so outstanding reads plus buffered pixels never exceed FIFO_DEPTH.
// Ports: sys_clk/sys_rst; enable, fb_base; mem_req/mem_addr/mem_gnt request side;
//        mem_rvld/mem_rdata in-order responses; line_buffer_data/_vld/_rdy output; frame_done pulse.
`include "vga.svh"

module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int RGB_SIZE   = 12,
    parameter int H_DISPLAY  = `H_DISPLAY,
    parameter int V_DISPLAY  = `V_DISPLAY,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [AW-1:0]       fb_base,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rvld,
    input  logic [RGB_SIZE-1:0] mem_rdata,
    output logic [RGB_SIZE:0]   line_buffer_data,
    output logic                line_buffer_vld,
    input  logic                line_buffer_rdy,
    output logic                frame_done
);

    localparam int XW = cnt_width(H_DISPLAY);
    localparam int YW = cnt_width(V_DISPLAY);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              first_q, first_d;

    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok;
    logic              grant;
    logic              rsp_vld;
    logic              pop;
    logic              last_px;
    logic              tag_full, tag_empty;
    logic              pix_full, pix_empty;
    logic [1:0]        tag_rdata;
    logic [RGB_SIZE+1:0] pix_rdata;

    assign last_px = (x_q == XW'(H_DISPLAY - 1)) && (y_q == YW'(V_DISPLAY - 1));

    // Reads in flight plus pixels already buffered must leave room for one more.
    // The full flags are redundant with the sum but keep the request low on their own.
    assign credit_ok = (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C)
                       && !tag_full && !pix_full;

    assign grant    = mem_req && mem_gnt;
    // A response with nothing outstanding (e.g. straight after reset) is dropped.
    assign rsp_vld  = mem_rvld && !tag_empty;
    assign mem_addr = addr_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        first_d = first_q;
        mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = READ;
                    addr_d  = fb_base;
                    x_d     = '0;
                    y_d     = '0;
                    first_d = 1'b1;
                end
            end
            READ: begin
                mem_req = credit_ok;
                if (credit_ok && mem_gnt) begin
                    addr_d  = addr_q + AW'(1);
                    first_d = 1'b0;
                    if (x_q == XW'(H_DISPLAY - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_px) begin
                        y_d     = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // enable is only looked at here, so a frame always runs to its end.
                if (outstanding == '0) begin
                    if (enable) begin
                        state_d = READ;
                        addr_d  = fb_base;
                        x_d     = '0;
                        y_d     = '0;
                        first_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-request tag {last, first} travels alongside the read; its occupancy is
    // the outstanding-read count, and its head matches the next response.
    vga_sync_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (grant),
        .wdata ({last_px, first_q}),
        .pop   (rsp_vld),
        .rdata (tag_rdata),
        .full  (tag_full),
        .empty (tag_empty),
        .count (outstanding)
    );

    assign pop = line_buffer_vld && line_buffer_rdy;

    vga_sync_fifo #(
        .WIDTH (RGB_SIZE + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (rsp_vld),
        .wdata ({tag_rdata, mem_rdata}),
        .pop   (pop),
        .rdata (pix_rdata),
        .full  (pix_full),
        .empty (pix_empty),
        .count (fifo_count)
    );

    assign line_buffer_vld  = !pix_empty;
    assign line_buffer_data = pix_rdata[RGB_SIZE:0];
    assign frame_done       = pop && pix_rdata[RGB_SIZE+1];

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    localparam int RGB   = 12;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 19;
    localparam int DEPTH = 4;
    localparam int NPIX  = H * V;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic           enable;
    logic [AW-1:0]  fb_base;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_gnt = 1'b0;
    logic           mem_rvld = 1'b0;
    logic [RGB-1:0] mem_rdata = '0;
    logic [RGB:0]   line_buffer_data;
    logic           line_buffer_vld;
    logic           line_buffer_rdy = 1'b0;
    logic           frame_done;

    vga_frame_reader #(
        .RGB_SIZE   (RGB),
        .H_DISPLAY  (H),
        .V_DISPLAY  (V),
        .AW         (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .fb_base          (fb_base),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvld         (mem_rvld),
        .mem_rdata        (mem_rdata),
        .line_buffer_data (line_buffer_data),
        .line_buffer_vld  (line_buffer_vld),
        .line_buffer_rdy  (line_buffer_rdy),
        .frame_done       (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RGB-1:0] data_of(input logic [AW-1:0] a);
        logic [RGB-1:0] lo;
        lo = a[RGB-1:0];
        return lo ^ 12'hA5C;
    endfunction

    // Controls written only by the stimulus block.
    logic          gnt_rand   = 1'b0;
    logic          rdy_hold   = 1'b0;
    logic          stray_rvld = 1'b0;
    int            lat_min    = 1;
    int            lat_max    = 1;
    logic [AW-1:0] exp_base   = 19'h100;

    // Memory / scoreboard state written only by the model block.
    typedef struct {
        int             due;
        logic [RGB-1:0] d;
    } rsp_t;
    rsp_t           pend[$];
    logic [RGB+1:0] exp_q[$];
    int             cyc        = 0;
    int             gidx       = 0;
    int             grants     = 0;
    int             done_cnt   = 0;
    int             over_cnt   = 0;
    int             t_first    = 0;
    int             t_done     = 0;
    logic [AW-1:0]  cur_base   = '0;
    logic [AW-1:0]  first_addr = '0;
    rsp_t           r;
    logic [RGB+1:0] e;

    // Memory model and output scoreboard: inputs for the coming edge are driven
    // at the falling edge, outputs are sampled 1 time unit later.
    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            pend.delete();
            exp_q.delete();
            gidx            = 0;
            mem_gnt         = 1'b0;
            mem_rvld        = 1'b0;
            mem_rdata       = '0;
            line_buffer_rdy = 1'b0;
        end else begin
            mem_gnt         = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            line_buffer_rdy = !rdy_hold;
            if (stray_rvld) begin
                mem_rvld  = 1'b1;
                mem_rdata = 12'hFFF;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvld  = 1'b1;
                mem_rdata = pend[0].d;
                void'(pend.pop_front());
            end else begin
                mem_rvld  = 1'b0;
                mem_rdata = '0;
            end
            if (mem_req && mem_gnt) begin
                if (gidx == 0) begin
                    cur_base   = exp_base;
                    first_addr = mem_addr;
                end
                check("req_addr", 32'(mem_addr), 32'(cur_base + AW'(gidx)));
                r.due = cyc + int'($urandom_range(lat_min, lat_max));
                r.d   = data_of(mem_addr);
                pend.push_back(r);
                exp_q.push_back({gidx == NPIX - 1, gidx == 0, r.d});
                if (exp_q.size() > DEPTH) over_cnt++;
                gidx = (gidx + 1) % NPIX;
                grants++;
            end
            #1;
            if (line_buffer_vld && line_buffer_rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(line_buffer_data), 32'(e[RGB:0]));
                    check("out_done", 32'(frame_done), 32'(e[RGB+1]));
                    if (e[RGB]) t_first = cyc;
                    if (frame_done) begin
                        t_done = cyc;
                        done_cnt++;
                    end
                end
            end else begin
                check("done_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    task automatic wait_grants(input int target, input string tag);
        for (int i = 0; i < 3000 && grants < target; i++) begin
            @(posedge sys_clk); #1;
        end
        check(tag, 32'(grants >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 5000 && done_cnt < target; i++) begin
            @(posedge sys_clk); #1;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 6; i++) begin
            @(posedge sys_clk); #1;
            if (!mem_req && exp_q.size() == 0 && pend.size() == 0) quiet++;
            else quiet = 0;
        end
        check(tag, 32'(quiet >= 6), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  32'(mem_req), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_vld"},  32'(line_buffer_vld), 32'd0);
        check({tag, "_data"}, 32'(line_buffer_data), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    int g0;
    int d0;

    initial begin
        sys_rst = 1'b1;
        enable  = 1'b0;
        fb_base = 19'h100;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        check("idle_no_req", 32'(mem_req), 32'd0);

        // One frame, ideal memory: request one cycle after start, 1 pixel/cycle.
        g0 = grants; d0 = done_cnt;
        enable = 1'b1;
        @(posedge sys_clk); #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(mem_addr), 32'h100);
        enable = 1'b0;
        wait_done(d0 + 1, "frame1_done");
        wait_idle("frame1_idle");
        check("frame1_grants", 32'(grants - g0), 32'd8);
        check("frame1_dones", 32'(done_cnt - d0), 32'd1);
        check("throughput", 32'(t_done - t_first), 32'd7);

        // Output stalled for 20 cycles mid-frame.
        g0 = grants;
        enable = 1'b1;
        wait_grants(g0 + 3, "stall_start");
        rdy_hold = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        check("stall_req_low", 32'(mem_req), 32'd0);
        check("stall_inflight", 32'(exp_q.size()), 32'(DEPTH));
        check("stall_over", 32'(over_cnt), 32'd0);
        rdy_hold = 1'b0;
        wait_grants(g0 + 12, "stall_resume");
        enable = 1'b0;
        wait_idle("stall_idle");
        check("stall_whole_frames", 32'((grants - g0) % NPIX), 32'd0);

        // Random grant and latency 1..6.
        g0 = grants; d0 = done_cnt;
        gnt_rand = 1'b1;
        lat_min  = 1;
        lat_max  = 6;
        enable   = 1'b1;
        wait_done(d0 + 3, "rand_frames");
        enable = 1'b0;
        wait_idle("rand_idle");
        check("rand_whole_frames", 32'((grants - g0) % NPIX), 32'd0);
        check("rand_done_count", 32'(done_cnt - d0), 32'((grants - g0) / NPIX));
        gnt_rand = 1'b0;
        lat_max  = 1;

        // enable dropped at pixel 3: frame still completes, then idle.
        g0 = grants; d0 = done_cnt;
        enable = 1'b1;
        wait_grants(g0 + 3, "drop_pix3");
        enable = 1'b0;
        wait_idle("drop_idle");
        check("drop_grants", 32'(grants - g0), 32'd8);
        check("drop_dones", 32'(done_cnt - d0), 32'd1);
        repeat (10) @(posedge sys_clk);
        #1;
        check("drop_no_req", 32'(mem_req), 32'd0);

        // fb_base moved mid-frame: takes effect at the next frame.
        g0 = grants;
        enable = 1'b1;
        wait_grants(g0 + 3, "base_pix3");
        fb_base  = 19'h200;
        exp_base = 19'h200;
        wait_grants(g0 + 9, "base_next");
        enable = 1'b0;
        wait_idle("base_idle");
        check("base_grants", 32'(grants - g0), 32'd16);
        check("base_new_start", 32'(first_addr), 32'h200);

        // Reset with reads outstanding, then a stray response right after.
        lat_min = 6;
        lat_max = 6;
        enable  = 1'b1;
        for (int i = 0; i < 200 && pend.size() < 3; i++) begin
            @(posedge sys_clk); #1;
        end
        check("rst_outstanding", 32'(pend.size() >= 3), 32'd1);
        sys_rst = 1'b1;
        enable  = 1'b0;
        @(posedge sys_clk); #1;
        check_reset_outputs("midrst");
        sys_rst    = 1'b0;
        lat_min    = 1;
        lat_max    = 1;
        stray_rvld = 1'b1;
        @(posedge sys_clk); #1;
        stray_rvld = 1'b0;
        @(posedge sys_clk); #1;
        check("stray_ignored", 32'(line_buffer_vld), 32'd0);

        fb_base  = 19'h180;
        exp_base = 19'h180;
        g0 = grants; d0 = done_cnt;
        enable = 1'b1;
        wait_grants(g0 + 1, "restart_go");
        enable = 1'b0;
        wait_idle("restart_idle");
        check("restart_grants", 32'(grants - g0), 32'd8);
        check("restart_base", 32'(first_addr), 32'h180);
        check("restart_dones", 32'(done_cnt - d0), 32'd1);
        check("never_over", 32'(over_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
